// File: rtl/config_loader.sv
// config_loader: serial bitstream loader writing WORD_W-bit words into NUM_ROWS fabric rows.
// Optional CRC-8 check of the stream is enabled by defining CFG_LOADER_CRC_EN.
// configs_in is captured on the final bit of each word, so the row being written
// sees its word with its enable through both COMMIT and ADVANCE.
module config_loader #(
    parameter int WORD_W        = 384,
    parameter int NUM_ROWS      = 267,
    parameter int SETTLE_CYCLES = 10
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                cfg_start_i,
    input  logic                cfg_bit_i,
    input  logic                cfg_valid_i,
    output logic                cfg_ready_o,
    output logic [WORD_W-1:0]   configs_in_o,
    output logic [NUM_ROWS-1:0] configs_en_o,
    output logic                ff_en_o,
    output logic                rdy_o,
    output logic                cfg_err_o
);
    localparam int BW = $clog2(WORD_W + 1);
    localparam int RW = $clog2(NUM_ROWS + 1);
    localparam int SW = $clog2(SETTLE_CYCLES + 2);
    localparam logic [BW-1:0] LAST_BIT    = BW'(WORD_W - 1);
    localparam logic [RW-1:0] LAST_ROW    = RW'(NUM_ROWS - 1);
    localparam logic [SW-1:0] LAST_SETTLE = SW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

    typedef enum logic [2:0] {IDLE, SHIFT, COMMIT, ADVANCE, CHECK, SETTLE, DONE, ERROR} state_t;

    state_t                state_q, state_d;
    logic [WORD_W-1:0]     shift_q, shift_d;
    logic [WORD_W-1:0]     cin_q, cin_d;
    logic [NUM_ROWS-1:0]   en_q, en_d;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [RW-1:0]         row_cnt_q, row_cnt_d;
    logic [SW-1:0]         settle_q, settle_d;
    logic                  ff_en_q, ff_en_d;
    logic                  rdy_q, rdy_d;
    logic                  xfer, start_ok;
    logic [WORD_W-1:0]     shifted;
`ifdef CFG_LOADER_CRC_EN
    logic [7:0]            crc_q, crc_d;
    logic [7:0]            rx_q, rx_d;
    logic [3:0]            rx_cnt_q, rx_cnt_d;
    logic                  err_q, err_d;
    logic [7:0]            rx_next;

    assign cfg_ready_o = (state_q == SHIFT) || (state_q == CHECK);
    assign cfg_err_o   = err_q;
    assign rx_next     = {rx_q[6:0], cfg_bit_i};
`else
    assign cfg_ready_o = (state_q == SHIFT);
    assign cfg_err_o   = 1'b0;
`endif

    assign xfer         = cfg_valid_i && cfg_ready_o;
    assign start_ok     = cfg_start_i && (state_q == IDLE || state_q == DONE || state_q == ERROR);
    assign shifted      = {shift_q[WORD_W-2:0], cfg_bit_i};
    assign configs_in_o = cin_q;
    assign configs_en_o = en_q;
    assign ff_en_o      = ff_en_q;
    assign rdy_o        = rdy_q;

    // Next-state and datapath updates for the load sequence
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        cin_d     = cin_q;
        en_d      = en_q;
        bit_cnt_d = bit_cnt_q;
        row_cnt_d = row_cnt_q;
        settle_d  = (state_q == SETTLE) ? settle_q + 1'b1 : '0;
        ff_en_d   = ff_en_q;
        rdy_d     = rdy_q;
`ifdef CFG_LOADER_CRC_EN
        crc_d     = crc_q;
        rx_d      = rx_q;
        rx_cnt_d  = rx_cnt_q;
        err_d     = err_q;
`endif
        if (start_ok) begin
            state_d   = SHIFT;
            en_d      = NUM_ROWS'(1);
            bit_cnt_d = '0;
            row_cnt_d = '0;
            ff_en_d   = 1'b0;
            rdy_d     = 1'b0;
`ifdef CFG_LOADER_CRC_EN
            crc_d     = '0;
            rx_cnt_d  = '0;
            err_d     = 1'b0;
`endif
        end else begin
            case (state_q)
                SHIFT: begin
                    if (xfer) begin
                        shift_d   = shifted;
                        bit_cnt_d = bit_cnt_q + 1'b1;
`ifdef CFG_LOADER_CRC_EN
                        crc_d     = {crc_q[6:0], 1'b0} ^ (8'h07 & {8{crc_q[7] ^ cfg_bit_i}});
`endif
                        if (bit_cnt_q == LAST_BIT) begin
                            bit_cnt_d = '0;
                            cin_d     = shifted;
                            state_d   = COMMIT;
                        end
                    end
                end
                COMMIT: state_d = ADVANCE;
                ADVANCE: begin
                    en_d      = en_q << 1;
                    row_cnt_d = row_cnt_q + 1'b1;
                    state_d   = (row_cnt_q == LAST_ROW) ? CHECK : SHIFT;
                end
                CHECK: begin
`ifdef CFG_LOADER_CRC_EN
                    if (xfer) begin
                        rx_d     = rx_next;
                        rx_cnt_d = rx_cnt_q + 1'b1;
                        if (rx_cnt_q == 4'd7) begin
                            state_d = (rx_next == crc_q) ? SETTLE : ERROR;
                            err_d   = (rx_next != crc_q);
                        end
                    end
`else
                    state_d = SETTLE;
`endif
                end
                SETTLE: begin
                    if (settle_q == LAST_SETTLE) begin
                        state_d = DONE;
                        ff_en_d = 1'b1;
                    end
                end
                DONE: rdy_d = 1'b1;
                default: ;
            endcase
        end
    end

    // State register with synchronous reset to the idle, row-0 configuration
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            cin_q     <= '0;
            en_q      <= NUM_ROWS'(1);
            bit_cnt_q <= '0;
            row_cnt_q <= '0;
            settle_q  <= '0;
            ff_en_q   <= 1'b0;
            rdy_q     <= 1'b0;
`ifdef CFG_LOADER_CRC_EN
            crc_q     <= '0;
            rx_q      <= '0;
            rx_cnt_q  <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            cin_q     <= cin_d;
            en_q      <= en_d;
            bit_cnt_q <= bit_cnt_d;
            row_cnt_q <= row_cnt_d;
            settle_q  <= settle_d;
            ff_en_q   <= ff_en_d;
            rdy_q     <= rdy_d;
`ifdef CFG_LOADER_CRC_EN
            crc_q     <= crc_d;
            rx_q      <= rx_d;
            rx_cnt_q  <= rx_cnt_d;
            err_q     <= err_d;
`endif
        end
    end
endmodule

// File: tb/tb_config_loader.sv
// tb_config_loader: randomized scoreboard bench for config_loader (honours CFG_LOADER_CRC_EN).
module tb_config_loader;
    localparam int W = 8;
    localparam int R = 3;
    localparam int S = 10;

    typedef struct {
        logic [R-1:0] en;
        logic [W-1:0] word;
    } row_t;

    logic         clk = 1'b0, rst = 1'b1, start = 1'b0, cbit = 1'b0, valid = 1'b0;
    logic         ready, ff_en, rdy, err;
    logic [W-1:0] cin;
    logic [R-1:0] cen;
    int           errors = 0, checks = 0, cyc = 0, ff_cyc = 0;
    row_t         row_q[$];
    int           ff_q[$];
    logic [R-1:0] p_en = '0;
    logic [W-1:0] p_in = '0;
    logic         p_ff = 1'b0, p_rdy = 1'b0;

    config_loader #(.WORD_W(W), .NUM_ROWS(R), .SETTLE_CYCLES(S)) dut (
        .clk_i(clk), .rst_i(rst), .cfg_start_i(start), .cfg_bit_i(cbit), .cfg_valid_i(valid),
        .cfg_ready_o(ready), .configs_in_o(cin), .configs_en_o(cen),
        .ff_en_o(ff_en), .rdy_o(rdy), .cfg_err_o(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_cfg_ready"}, 64'(ready), 64'(0));
        check({tag, "_configs_in"}, 64'(cin), 64'(0));
        check({tag, "_configs_en"}, 64'(cen), 64'(1));
        check({tag, "_ff_en"}, 64'(ff_en), 64'(0));
        check({tag, "_rdy"}, 64'(rdy), 64'(0));
        check({tag, "_cfg_err"}, 64'(err), 64'(0));
    endtask

`ifdef CFG_LOADER_CRC_EN
    // CRC as remainder of message * x^8 divided by x^8+x^2+x+1
    function automatic logic [7:0] ref_crc(input bit m[$]);
        logic [8:0] r;
        r = '0;
        for (int i = 0; i < m.size() + 8; i++) begin
            r = {r[7:0], (i < m.size()) ? m[i] : 1'b0};
            if (r[8]) r = r ^ 9'h107;
        end
        return r[7:0];
    endfunction
`endif

    // Monitor: a row write is seen when configs_en steps left; ff_en/rdy rises are timed
    always @(negedge clk) begin : monitor
        row_t e;
        if (p_en != '0 && cen == R'(p_en << 1)) begin
            if (row_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL row_unexpected: got en=%0h in=%0h, expected no row write", p_en, p_in);
            end else begin
                e = row_q.pop_front();
                check("row_en", 64'(p_en), 64'(e.en));
                check("row_word", 64'(p_in), 64'(e.word));
            end
        end
        if (ff_en && !p_ff) begin
            if (ff_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL ff_en_unexpected: got rise at cycle %0d, expected none", cyc);
            end else begin
                check("ff_en_rise_cycle", 64'(cyc), 64'(ff_q.pop_front()));
            end
            ff_cyc <= cyc;
        end
        if (rdy && !p_rdy) check("rdy_rise_cycle", 64'(cyc), 64'(ff_cyc + 1));
        p_en  <= cen;
        p_in  <= cin;
        p_ff  <= ff_en;
        p_rdy <= rdy;
    end

    task automatic send_bit(input logic b, input logic pulse, input bit gaps, output int edge_n);
        int  n;
        logic ok;
        n = 0;
        do begin
            @(negedge clk);
            start = pulse && (n == 0);
            valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            cbit  = valid ? b : 1'($urandom);
            ok    = valid && ready;
            n++;
        end while (!ok && n < 60);
        if (!ok) begin
            checks++; errors++;
            $display("FAIL bit_timeout: got no cfg_ready in 60 cycles, expected a transfer");
        end
        edge_n = cyc + 1;
    endtask

    task automatic load(input bit gaps, input int pulse_at, input int rst_at, input bit bad);
        logic [W-1:0] words[R];
        bit           msg[$];
        int           e, n;
        logic [7:0]   crc;
        e = 0;
        for (int r = 0; r < R; r++) begin
            words[r] = W'($urandom);
            for (int i = 0; i < W; i++) msg.push_back(words[r][W-1-i]);
        end
        @(negedge clk);
        start = 1'b1;
        n = 0;
        for (int r = 0; r < R; r++) begin
            for (int i = 0; i < W; i++) begin
                if (n == rst_at) begin
                    @(negedge clk);
                    start = 1'b0; valid = 1'b0; rst = 1'b1;
                    @(negedge clk);
                    rst = 1'b0;
                    check_reset("midload_rst");
                    return;
                end
                send_bit(words[r][W-1-i], 1'(n == pulse_at), gaps, e);
                if (i == W - 1) row_q.push_back('{R'(1) << r, words[r]});
                n++;
            end
        end
`ifdef CFG_LOADER_CRC_EN
        crc = ref_crc(msg);
        if (bad) crc = crc ^ 8'(1 << $urandom_range(0, 7));
        for (int k = 0; k < 8; k++) send_bit(crc[7-k], 1'b0, gaps, e);
        if (!bad) ff_q.push_back(e + S);
`else
        crc = 8'(bad);
        ff_q.push_back(e + 3 + S);
`endif
        @(negedge clk);
        valid = 1'b0; start = 1'b0;
        repeat (S + 20) @(negedge clk);
        if (crc != 8'h00 && bad) begin
            check("bad_cfg_err", 64'(err), 64'(1));
            check("bad_ff_en", 64'(ff_en), 64'(0));
            check("bad_rdy", 64'(rdy), 64'(0));
        end else begin
            check("done_ff_en", 64'(ff_en), 64'(1));
            check("done_rdy", 64'(rdy), 64'(1));
            check("done_cfg_err", 64'(err), 64'(0));
            check("done_configs_en", 64'(cen), 64'(0));
            check("done_configs_in", 64'(cin), 64'(words[R-1]));
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst = 1'b0;
        @(negedge clk);
        check_reset("idle");
        load(1'b0, -1, -1, 1'b0);
        load(1'b1, -1, -1, 1'b0);
        load(1'b1, -1, 13, 1'b0);
        load(1'b1, -1, -1, 1'b0);
        load(1'b0, 10, -1, 1'b0);
`ifdef CFG_LOADER_CRC_EN
        load(1'b1, -1, -1, 1'b1);
        load(1'b1, -1, -1, 1'b0);
`endif
        repeat (3) @(negedge clk);
        check("rows_drained", 64'(row_q.size()), 64'(0));
        check("ff_drained", 64'(ff_q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200000, expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/config_loader.md
CONFIG_LOADER -- requirements
Module: config_loader

Interface
REQ-001 Parameter WORD_W, default 384, width of one fabric configuration word.
REQ-002 Parameter NUM_ROWS, default 267, number of configuration rows (width of configs_en).
REQ-003 Parameter SETTLE_CYCLES, default 10, idle cycles between last row write and ff_en assertion.
REQ-004 clock  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 cfg_start  input  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERROR.
REQ-007 cfg_bit  input  1  serial bitstream data, MSB of each word first.
REQ-008 cfg_valid  input  1  cfg_bit qualifier from the external programmer.
REQ-009 cfg_ready  output  1  loader can accept a bit; a bit transfers when cfg_valid && cfg_ready.
REQ-010 configs_in  output  WORD_W  word presented to the fabric.
REQ-011 configs_en  output  NUM_ROWS  one-hot row enable to the fabric.
REQ-012 ff_en  output  1  fabric flip-flop enable; high only after a complete, good load.
REQ-013 rdy  output  1  load complete, design running.
REQ-014 cfg_err  output  1  load failed; sticky until cfg_start or rst.

Function
REQ-015 States SHALL be IDLE, SHIFT, COMMIT, ADVANCE, CHECK, SETTLE, DONE and ERROR.
REQ-016 In IDLE, a cfg_start pulse SHALL load configs_en=1 (row 0), clear the bit and row counters, clear ff_en, rdy and cfg_err, and enter SHIFT.
REQ-017 cfg_ready SHALL be high only in SHIFT and CHECK, and low in all other states.
REQ-018 In SHIFT, each transferred bit SHALL be shifted into a WORD_W-bit shift register at the LSB, and the bit counter SHALL increment.
REQ-019 Transferring bit WORD_W-1 SHALL move the state to COMMIT; cfg_valid low SHALL stall without loss.
REQ-020 COMMIT (1 cycle) SHALL copy the shift register to configs_in; configs_in SHALL otherwise hold its value.
REQ-021 ADVANCE (1 cycle) SHALL shift configs_en left by 1 and increment the row counter; the current row therefore sees its word for at least 2 cycles.
REQ-022 After ADVANCE for row NUM_ROWS-1, configs_en SHALL be all-zero and the state SHALL go to CHECK; otherwise the state SHALL return to SHIFT with the bit counter at 0.
REQ-023 CHECK behaviour is defined under Configuration.
REQ-024 SETTLE SHALL count SETTLE_CYCLES cycles, then enter DONE.
REQ-025 On entry to DONE, ff_en SHALL go high; rdy SHALL go high exactly one cycle later.
REQ-026 Both ff_en and rdy SHALL remain high until rst or cfg_start.
REQ-027 A cfg_start pulse in states other than IDLE, DONE and ERROR SHALL be ignored.
REQ-028 A cfg_start pulse in DONE or ERROR SHALL restart per REQ-016.
REQ-029 If rst and cfg_start are high in the same cycle, rst SHALL win.
REQ-030 The row counter SHALL be wide enough for NUM_ROWS and SHALL never wrap within a load.

Reset
REQ-031 With rst high at a clock edge, the next state SHALL be IDLE from any state, including mid-load.
REQ-032 Reset values: configs_in=0, configs_en=1, cfg_ready=0, ff_en=0, rdy=0, cfg_err=0, all counters 0, shift register 0.

Configuration
REQ-033 Macro CFG_LOADER_CRC_EN selects whether the load is CRC-checked.
REQ-034 With CFG_LOADER_CRC_EN defined, a CRC-8 (poly 0x07, init 0x00) SHALL run over every bit transferred in SHIFT.
REQ-035 With CFG_LOADER_CRC_EN defined, CHECK SHALL accept 8 further bits, MSB first, and compare them with the CRC.
REQ-036 With CFG_LOADER_CRC_EN defined, a CRC match SHALL enter SETTLE.
REQ-037 With CFG_LOADER_CRC_EN defined, a CRC mismatch SHALL enter ERROR: cfg_err=1, ff_en=0, rdy=0.
REQ-038 With CFG_LOADER_CRC_EN undefined, CHECK SHALL last 1 cycle with cfg_ready=0, then go to SETTLE; cfg_err SHALL be tied 0 and no CRC logic SHALL exist.

Verification
REQ-039 WORD_W=8, NUM_ROWS=3, 24 bits sent back-to-back -> configs_in takes words 0, 1, 2 while configs_en is 001, 010, 100 respectively; configs_en=000 after the last ADVANCE.
REQ-040 Same load with SETTLE_CYCLES=10 -> ff_en rises 10 cycles after CHECK exits, and rdy rises one cycle after ff_en.
REQ-041 cfg_valid toggled 1-0-1 randomly during a word -> identical configs_in values to REQ-039, with no lost or duplicated bits.
REQ-042 rst pulsed after 13 bits, then a fresh cfg_start and a full stream -> outputs at reset values after rst, then a correct full load.
REQ-043 With CFG_LOADER_CRC_EN defined: correct CRC byte -> rdy=1; CRC byte with one bit flipped -> cfg_err=1, ff_en stays 0.
REQ-044 cfg_start pulsed mid-SHIFT -> ignored, load completes normally.
